// File: rtl/dmem_bridge_if.sv
// Memory-side request/ready bus between dmem_bridge and a variable-latency data memory.
// The bridge drives requests through the master modport; the memory uses the slave modport.
interface dmem_bridge_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/dmem_bridge.sv
// Turns the core's single-cycle data-memory accesses into req/ready transactions.
// It stalls the core until each access completes and raises a sticky error if the memory never answers.
module dmem_bridge #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] address_DMEM,
    input  logic [DATA_W-1:0] write_data_DMEM,
    output logic [DATA_W-1:0] data_DMEM,
    output logic              stall,
    output logic              err,
    dmem_bridge_if.master     mem
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] data_q;
    logic              err_q;

    // The transaction fields are captured once in IDLE and held from registers for the whole REQ phase,
    // so the core is free to present anything on its inputs while it is stalled.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (MemRead || MemWrite) begin
                        addr_q  <= address_DMEM;
                        wdata_q <= write_data_DMEM;
                        we_q    <= MemWrite;
                        req_q   <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (mem.mem_ready) begin
                        if (!we_q) begin
                            data_q <= mem.mem_rdata;
                        end
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                        req_q      <= 1'b0;
                        state_q    <= DONE;
                    end else if (wait_cnt_q == LAST_WAIT) begin
                        // Abort: retire the instruction anyway so the core cannot hang forever.
                        err_q <= 1'b1;
                        if (!we_q) begin
                            data_q <= '0;
                        end
                        req_q   <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    wait_cnt_q <= '0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Stall has to rise in the same cycle the core presents its request, so it is decoded combinationally.
    // It is forced low while reset is asserted.
    always_comb begin
        stall = RSTn && (((state_q == IDLE) && (MemRead || MemWrite)) || (state_q == REQ));
    end

    assign data_DMEM     = data_q;
    assign err           = err_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
endmodule

// File: tb/tb_dmem_bridge.sv
// Directed testbench for dmem_bridge: a scoreboard of expected transactions is checked as the bridge issues them.
module tb_dmem_bridge;
    localparam int TIMEOUT = 16;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [9:0]  address_DMEM = '0;
    logic [31:0] write_data_DMEM = '0;
    logic [31:0] data_DMEM;
    logic        stall;
    logic        err;

    dmem_bridge_if #(.ADDR_W(10), .DATA_W(32)) mem ();

    dmem_bridge #(.ADDR_W(10), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .CLK             (CLK),
        .RSTn            (RSTn),
        .MemRead         (MemRead),
        .MemWrite        (MemWrite),
        .address_DMEM    (address_DMEM),
        .write_data_DMEM (write_data_DMEM),
        .data_DMEM       (data_DMEM),
        .stall           (stall),
        .err             (err),
        .mem             (mem)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t        sbQ[$];
    int          passCount = 0;
    int          checkCount = 0;
    int          cyc = 0;
    int          lastDoneCyc = 0;
    logic [31:0] expData = '0;
    logic        expErr = 1'b0;

    always @(posedge CLK) cyc++;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Drives one core access starting just after a rising edge, plays the memory side, and checks the
    // transaction against the scoreboard. readyAt < 0 means the memory never answers.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [9:0] addr,
                                 input logic [31:0] wdata, input int readyAt,
                                 input logic [31:0] rdata, input bit checkGap);
        txn_t exp;
        int   stallCnt = 0;
        int   reqCnt = 0;
        int   expReq;
        bit   done = 1'b0;
        exp = '0;
        MemRead = rd;
        MemWrite = wr;
        address_DMEM = addr;
        write_data_DMEM = wdata;
        sbQ.push_back('{we: wr, addr: addr, wdata: wdata});
        expReq = (readyAt >= 0) ? readyAt + 1 : TIMEOUT;
        for (int c = 0; c < TIMEOUT + 8; c++) begin
            @(negedge CLK);
            if (stall) stallCnt++;
            if (mem.mem_req) begin
                reqCnt++;
                if (reqCnt == 1) begin
                    if (checkGap) checkOutput("b2b_gap", 32'(cyc - lastDoneCyc), 32'd2);
                    if (sbQ.size() == 0) begin
                        checkOutput("sb_pop", 32'd0, 32'd1);
                    end else begin
                        exp = sbQ.pop_front();
                        checkOutput("mem_we", 32'(mem.mem_we), 32'(exp.we));
                        checkOutput("mem_addr", 32'(mem.mem_addr), 32'(exp.addr));
                        checkOutput("mem_wdata", mem.mem_wdata, exp.wdata);
                    end
                    address_DMEM = ~addr;
                    write_data_DMEM = ~wdata;
                end else begin
                    checkOutput("hold_we", 32'(mem.mem_we), 32'(exp.we));
                    checkOutput("hold_addr", 32'(mem.mem_addr), 32'(exp.addr));
                    checkOutput("hold_wdata", mem.mem_wdata, exp.wdata);
                end
                if (readyAt >= 0 && reqCnt == readyAt + 1) begin
                    mem.mem_ready = 1'b1;
                    mem.mem_rdata = rdata;
                end
            end else if (reqCnt > 0) begin
                done = 1'b1;
                break;
            end
            @(posedge CLK);
            #1;
            mem.mem_ready = 1'b0;
            mem.mem_rdata = 32'h0;
        end
        if (!done) checkOutput("done_bound", 32'd0, 32'd1);
        if (!wr) expData = (readyAt >= 0) ? rdata : 32'h0;
        if (readyAt < 0) expErr = 1'b1;
        checkOutput("req_cycles", 32'(reqCnt), 32'(expReq));
        checkOutput("stall_cycles", 32'(stallCnt), 32'(expReq + 1));
        checkOutput("stall_done", 32'(stall), 32'd0);
        checkOutput("data_DMEM", data_DMEM, expData);
        checkOutput("err", 32'(err), 32'(expErr));
        lastDoneCyc = cyc;
        // A ready pulse during DONE must be ignored.
        mem.mem_ready = 1'b1;
        mem.mem_rdata = 32'hBADC0DE5;
        @(posedge CLK);
        #1;
        mem.mem_ready = 1'b0;
        mem.mem_rdata = 32'h0;
        MemRead = 1'b0;
        MemWrite = 1'b0;
        checkOutput("spurious_done_data", data_DMEM, expData);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        mem.mem_ready = 1'b0;
        mem.mem_rdata = 32'h0;
        #1;
        checkOutput("rst_mem_req", 32'(mem.mem_req), 32'd0);
        checkOutput("rst_mem_we", 32'(mem.mem_we), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem.mem_addr), 32'd0);
        checkOutput("rst_mem_wdata", mem.mem_wdata, 32'd0);
        checkOutput("rst_data", data_DMEM, 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_stall", 32'(stall), 32'd0);
        @(negedge CLK);
        RSTn = 1'b1;
        @(posedge CLK);
        #1;

        // Zero-wait read, then back-to-back write with 3 wait cycles and a timed-out read.
        applyStimulus(1'b1, 1'b0, 10'h005, 32'h0, 0, 32'h12345678, 1'b0);
        applyStimulus(1'b0, 1'b1, 10'h3FF, 32'hCAFEF00D, 3, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, 10'h0AA, 32'h0, -1, 32'h0, 1'b1);
        // Read and write together: the write must win, then a read follows with no gap.
        applyStimulus(1'b1, 1'b1, 10'h155, 32'h55AA55AA, 1, 32'hFFFFFFFF, 1'b1);
        applyStimulus(1'b1, 1'b0, 10'h2A0, 32'h0, 2, 32'hA5A50F0F, 1'b1);

        // Spurious ready while idle.
        mem.mem_ready = 1'b1;
        mem.mem_rdata = 32'hDEADBEEF;
        @(negedge CLK);
        checkOutput("idle_ready_req", 32'(mem.mem_req), 32'd0);
        checkOutput("idle_ready_stall", 32'(stall), 32'd0);
        @(posedge CLK);
        #1;
        mem.mem_ready = 1'b0;
        mem.mem_rdata = 32'h0;
        checkOutput("idle_ready_data", data_DMEM, expData);
        checkOutput("idle_ready_req2", 32'(mem.mem_req), 32'd0);

        // Asynchronous reset in the middle of a waiting read.
        MemRead = 1'b1;
        address_DMEM = 10'h011;
        repeat (3) @(posedge CLK);
        #2;
        checkOutput("pre_rst_req", 32'(mem.mem_req), 32'd1);
        checkOutput("pre_rst_err", 32'(err), 32'd1);
        RSTn = 1'b0;
        #1;
        checkOutput("async_rst_req", 32'(mem.mem_req), 32'd0);
        checkOutput("async_rst_stall", 32'(stall), 32'd0);
        checkOutput("async_rst_err", 32'(err), 32'd0);
        checkOutput("async_rst_data", data_DMEM, 32'd0);
        MemRead = 1'b0;
        expData = 32'h0;
        expErr = 1'b0;
        @(negedge CLK);
        RSTn = 1'b1;
        @(posedge CLK);
        #1;
        applyStimulus(1'b1, 1'b0, 10'h077, 32'h0, 1, 32'h0BADF00D, 1'b0);

        checkOutput("sb_drained", 32'(sbQ.size()), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
